// File: rtl/alu_unit_if.sv
// alu_unit_if: op issue bundle and CDB result bundle for alu_unit.
// Opcode/ROB macros live here; ALU_PERF_CNT_EN adds perf counter wires.
`ifndef ALU_UNIT_DEFS
`define ALU_UNIT_DEFS
`define OPCODE_TYPE [5:0]
`define ROB_ID_RANGE [3:0]
`define NOP 6'd0
`define OP_LUI 6'd1
`define OP_AUIPC 6'd2
`define OP_JAL 6'd3
`define OP_JALR 6'd4
`define OP_BEQ 6'd5
`define OP_BNE 6'd6
`define OP_BLT 6'd7
`define OP_BGE 6'd8
`define OP_BLTU 6'd9
`define OP_BGEU 6'd10
`define OP_ADDI 6'd11
`define OP_SLTI 6'd12
`define OP_SLTIU 6'd13
`define OP_XORI 6'd14
`define OP_ORI 6'd15
`define OP_ANDI 6'd16
`define OP_SLLI 6'd17
`define OP_SRLI 6'd18
`define OP_SRAI 6'd19
`define OP_ADD 6'd20
`define OP_SUB 6'd21
`define OP_SLL 6'd22
`define OP_SLT 6'd23
`define OP_SLTU 6'd24
`define OP_XOR 6'd25
`define OP_SRL 6'd26
`define OP_SRA 6'd27
`define OP_OR 6'd28
`define OP_AND 6'd29
`endif

interface alu_unit_if;
  logic                rdy;
  logic                rollback_signal;
  logic `OPCODE_TYPE   optype_2alu;
  logic `ROB_ID_RANGE  rd_2alu;
  logic [31:0]         pc_2alu;
  logic [31:0]         Vi_2alu;
  logic [31:0]         Vj_2alu;
  logic [31:0]         imm_2alu;
  logic                alu_has_result;
  logic `ROB_ID_RANGE  alias_from_alu;
  logic [31:0]         result_from_alu;
  logic                alu_jump;
  logic [31:0]         alu_target_pc;
`ifdef ALU_PERF_CNT_EN
  logic [31:0]         perf_ops;
  logic [31:0]         perf_taken;
`endif

  modport master (
    output rdy, rollback_signal, optype_2alu, rd_2alu,
    output pc_2alu, Vi_2alu, Vj_2alu, imm_2alu,
    input  alu_has_result, alias_from_alu, result_from_alu,
    input  alu_jump, alu_target_pc
`ifdef ALU_PERF_CNT_EN
    , input perf_ops, perf_taken
`endif
  );

  modport slave (
    input  rdy, rollback_signal, optype_2alu, rd_2alu,
    input  pc_2alu, Vi_2alu, Vj_2alu, imm_2alu,
    output alu_has_result, alias_from_alu, result_from_alu,
    output alu_jump, alu_target_pc
`ifdef ALU_PERF_CNT_EN
    , output perf_ops, perf_taken
`endif
  );
endinterface

// File: rtl/alu_unit.sv
// alu_unit: 1-cycle integer ALU/branch unit; clk, rst (async low), bus.
// bus carries the RS op in and the registered CDB/jump result out; ALU_PERF_CNT_EN adds perf_ops/perf_taken.
module alu_unit (
  input logic       clk,
  input logic       rst,
  alu_unit_if.slave bus
);
  logic [31:0] pc, vi, vj, imm, pc4, pc_imm;
  logic [4:0]  sh_r, sh_i;
  logic        vld, jmp, br, take;
  logic [31:0] res, tgt;

  logic               has_q, has_d;
  logic               jmp_q, jmp_d;
  logic `ROB_ID_RANGE alias_q, alias_d;
  logic [31:0]        res_q, res_d;
  logic [31:0]        tgt_q, tgt_d;

  assign pc     = bus.pc_2alu;
  assign vi     = bus.Vi_2alu;
  assign vj     = bus.Vj_2alu;
  assign imm    = bus.imm_2alu;
  assign pc4    = pc + 32'd4;
  assign pc_imm = pc + imm;
  assign sh_r   = vj[4:0];
  assign sh_i   = imm[4:0];

  always_comb begin
    vld  = 1'b1;
    br   = 1'b0;
    take = 1'b0;
    res  = 32'd0;
    jmp  = 1'b0;
    tgt  = pc4;
    case (bus.optype_2alu)
      `OP_LUI:   res = imm;
      `OP_AUIPC: res = pc_imm;
      `OP_JAL: begin
        res = pc4;
        jmp = 1'b1;
        tgt = pc_imm;
      end
      `OP_JALR: begin
        res = pc4;
        jmp = 1'b1;
        tgt = (vi + imm) & ~32'd1;
      end
      `OP_BEQ:  begin br = 1'b1; take = vi == vj; end
      `OP_BNE:  begin br = 1'b1; take = vi != vj; end
      `OP_BLT:  begin br = 1'b1; take = $signed(vi) < $signed(vj); end
      `OP_BGE:  begin br = 1'b1; take = $signed(vi) >= $signed(vj); end
      `OP_BLTU: begin br = 1'b1; take = vi < vj; end
      `OP_BGEU: begin br = 1'b1; take = vi >= vj; end
      `OP_ADDI:  res = vi + imm;
      `OP_SLTI:  res = {31'd0, $signed(vi) < $signed(imm)};
      `OP_SLTIU: res = {31'd0, vi < imm};
      `OP_XORI:  res = vi ^ imm;
      `OP_ORI:   res = vi | imm;
      `OP_ANDI:  res = vi & imm;
      `OP_SLLI:  res = vi << sh_i;
      `OP_SRLI:  res = vi >> sh_i;
      `OP_SRAI:  res = $signed(vi) >>> sh_i;
      `OP_ADD:   res = vi + vj;
      `OP_SUB:   res = vi - vj;
      `OP_SLL:   res = vi << sh_r;
      `OP_SLT:   res = {31'd0, $signed(vi) < $signed(vj)};
      `OP_SLTU:  res = {31'd0, vi < vj};
      `OP_XOR:   res = vi ^ vj;
      `OP_SRL:   res = vi >> sh_r;
      `OP_SRA:   res = $signed(vi) >>> sh_r;
      `OP_OR:    res = vi | vj;
      `OP_AND:   res = vi & vj;
      default:   vld = 1'b0;
    endcase
    if (br) begin
      jmp = take;
      tgt = take ? pc_imm : pc4;
    end
  end

  // Rollback wins over rdy; a stalled unit keeps a pending result visible.
  always_comb begin
    has_d   = has_q;
    jmp_d   = jmp_q;
    alias_d = alias_q;
    res_d   = res_q;
    tgt_d   = tgt_q;
    if (bus.rollback_signal) begin
      has_d = 1'b0;
      jmp_d = 1'b0;
    end else if (bus.rdy) begin
      has_d = vld;
      jmp_d = vld & jmp;
      if (vld) begin
        alias_d = bus.rd_2alu;
        res_d   = res;
        tgt_d   = tgt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      has_q   <= 1'b0;
      jmp_q   <= 1'b0;
      alias_q <= '0;
      res_q   <= 32'd0;
      tgt_q   <= 32'd0;
    end else begin
      has_q   <= has_d;
      jmp_q   <= jmp_d;
      alias_q <= alias_d;
      res_q   <= res_d;
      tgt_q   <= tgt_d;
    end
  end

  assign bus.alu_has_result  = has_q;
  assign bus.alu_jump        = jmp_q;
  assign bus.alias_from_alu  = alias_q;
  assign bus.result_from_alu = res_q;
  assign bus.alu_target_pc   = tgt_q;

`ifdef ALU_PERF_CNT_EN
  logic        fire;
  logic [31:0] ops_q, ops_d;
  logic [31:0] tkn_q, tkn_d;

  assign fire = bus.rdy & ~bus.rollback_signal & vld;

  always_comb begin
    ops_d = ops_q;
    tkn_d = tkn_q;
    if (fire) begin
      ops_d = ops_q + 32'd1;
      if (jmp) tkn_d = tkn_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops_q <= 32'd0;
      tkn_q <= 32'd0;
    end else begin
      ops_q <= ops_d;
      tkn_q <= tkn_d;
    end
  end

  assign bus.perf_ops   = ops_q;
  assign bus.perf_taken = tkn_q;
`endif
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed + random check of alu_unit vs a behavioural model.
// Prints one summary line; mismatches print FAIL lines.
module tb_alu_unit;
  localparam logic [5:0] NOP = 6'd0, LUI = 6'd1, AUIPC = 6'd2;
  localparam logic [5:0] JAL = 6'd3, JALR = 6'd4, BEQ = 6'd5;
  localparam logic [5:0] BNE = 6'd6, BLT = 6'd7, BGE = 6'd8;
  localparam logic [5:0] BLTU = 6'd9, BGEU = 6'd10, ADDI = 6'd11;
  localparam logic [5:0] SLTI = 6'd12, SLTIU = 6'd13, XORI = 6'd14;
  localparam logic [5:0] ORI = 6'd15, ANDI = 6'd16, SLLI = 6'd17;
  localparam logic [5:0] SRLI = 6'd18, SRAI = 6'd19, ADD = 6'd20;
  localparam logic [5:0] SUB = 6'd21, SLL = 6'd22, SLT = 6'd23;
  localparam logic [5:0] SLTU = 6'd24, XOR = 6'd25, SRL = 6'd26;
  localparam logic [5:0] SRA = 6'd27, OR = 6'd28, AND = 6'd29;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;

  alu_unit_if bus ();

  alu_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic        e_has, e_jmp;
  logic [3:0]  e_alias;
  logic [31:0] e_res, e_tgt;
  logic [31:0] e_ops, e_tkn;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference semantics straight from the ISA rules, in plain integers.
  task automatic model(input logic [5:0] op, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, output logic v,
                       output logic [31:0] r, output logic j,
                       output logic [31:0] t);
    int sa, sb, si;
    sa = a; sb = b; si = im;
    v = 1'b1; r = 0; j = 1'b0; t = pc + 4;
    case (op)
      LUI:   r = im;
      AUIPC: r = pc + im;
      JAL:   begin r = pc + 4; j = 1; t = pc + im; end
      JALR:  begin r = pc + 4; j = 1; t = (a + im) & 32'hFFFF_FFFE; end
      BEQ:   j = (a == b);
      BNE:   j = (a != b);
      BLT:   j = (sa < sb);
      BGE:   j = !(sa < sb);
      BLTU:  j = (a < b);
      BGEU:  j = !(a < b);
      ADDI:  r = a + im;
      SLTI:  r = (sa < si) ? 1 : 0;
      SLTIU: r = (a < im) ? 1 : 0;
      XORI:  r = a ^ im;
      ORI:   r = a | im;
      ANDI:  r = a & im;
      SLLI:  r = a << (im % 32);
      SRLI:  r = a >> (im % 32);
      SRAI:  r = sa >>> (im % 32);
      ADD:   r = a + b;
      SUB:   r = a - b;
      SLL:   r = a << (b % 32);
      SLT:   r = (sa < sb) ? 1 : 0;
      SLTU:  r = (a < b) ? 1 : 0;
      XOR:   r = a ^ b;
      SRL:   r = a >> (b % 32);
      SRA:   r = sa >>> (b % 32);
      OR:    r = a | b;
      AND:   r = a & b;
      default: v = 1'b0;
    endcase
    if (op >= BEQ && op <= BGEU && j) t = pc + im;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [3:0] rd,
                        input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im);
    bus.optype_2alu = op;
    bus.rd_2alu = rd;
    bus.pc_2alu = pc;
    bus.Vi_2alu = a;
    bus.Vj_2alu = b;
    bus.imm_2alu = im;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".has"}, {31'd0, bus.alu_has_result}, {31'd0, e_has});
    chk({tag, ".jmp"}, {31'd0, bus.alu_jump}, {31'd0, e_jmp});
    chk({tag, ".alias"}, {28'd0, bus.alias_from_alu}, {28'd0, e_alias});
    chk({tag, ".res"}, bus.result_from_alu, e_res);
    chk({tag, ".tgt"}, bus.alu_target_pc, e_tgt);
`ifdef ALU_PERF_CNT_EN
    chk({tag, ".pops"}, bus.perf_ops, e_ops);
    chk({tag, ".ptkn"}, bus.perf_taken, e_tkn);
`endif
  endtask

  task automatic model_reset();
    e_has = 0; e_jmp = 0; e_alias = 0; e_res = 0; e_tgt = 0;
    e_ops = 0; e_tkn = 0;
  endtask

  // One clock: predict from current inputs, then check after the edge.
  task automatic step(input string tag);
    logic v, j;
    logic [31:0] r, t;
    model(bus.optype_2alu, bus.pc_2alu, bus.Vi_2alu, bus.Vj_2alu,
          bus.imm_2alu, v, r, j, t);
    @(posedge clk);
    #1;
    if (bus.rollback_signal) begin
      e_has = 0;
      e_jmp = 0;
    end else if (bus.rdy) begin
      e_has = v;
      e_jmp = v & j;
      if (v) begin
        e_alias = bus.rd_2alu;
        e_res = r;
        e_tgt = t;
        e_ops = e_ops + 1;
        if (j) e_tkn = e_tkn + 1;
      end
    end
    check_all(tag);
  endtask

  initial begin
    bus.rdy = 1'b1;
    bus.rollback_signal = 1'b0;
    set_op(NOP, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;
    #4;

    set_op(ADD, 5, 32'h200, 32'hFFFF_FFFF, 1, 0);
    step("add_wrap");
    chk("add_wrap.tgt_c", bus.alu_target_pc, 32'h204);
    chk("add_wrap.res_c", bus.result_from_alu, 0);
    chk("add_wrap.alias_c", {28'd0, bus.alias_from_alu}, 5);

    set_op(SRA, 1, 0, 32'h8000_0000, 32'h24, 0);
    step("sra");
    chk("sra.res_c", bus.result_from_alu, 32'hF800_0000);

    set_op(BLT, 2, 32'h100, 32'hFFFF_FFFF, 1, 32'h20);
    step("blt");
    chk("blt.tgt_c", bus.alu_target_pc, 32'h120);

    set_op(BLTU, 3, 32'h100, 32'hFFFF_FFFF, 1, 32'h20);
    step("bltu");
    chk("bltu.tgt_c", bus.alu_target_pc, 32'h104);

    set_op(JALR, 4, 32'h40, 32'h1003, 0, 4);
    step("jalr");
    chk("jalr.tgt_c", bus.alu_target_pc, 32'h1006);
    chk("jalr.res_c", bus.result_from_alu, 32'h44);

    set_op(NOP, 0, 0, 0, 0, 0);
    step("nop");
    set_op(6'd45, 7, 0, 1, 2, 3);
    step("badop");

    set_op(ADDI, 6, 32'h10, 7, 0, 5);
    step("rb_first");
    chk("rb_first.has_c", {31'd0, bus.alu_has_result}, 1);
    set_op(ADDI, 7, 32'h14, 8, 0, 5);
    bus.rollback_signal = 1'b1;
    step("rb_second");
    chk("rb_second.has_c", {31'd0, bus.alu_has_result}, 0);
    bus.rollback_signal = 1'b0;

    set_op(XOR, 9, 32'h80, 32'hF0F0, 32'h0FF0, 0);
    step("pre_stall");
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(ADD, 4'($urandom), $urandom, $urandom, $urandom, $urandom);
      step("stall");
      chk("stall.has_c", {31'd0, bus.alu_has_result}, 1);
    end
    bus.rdy = 1'b1;

    set_op(JAL, 3, 32'h300, 0, 0, 32'h40);
    step("pre_rst");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b1;
    set_op(ORI, 2, 32'h8, 32'h100, 0, 32'h3);
    step("post_rst");

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = $urandom;
      bus.rdy = ($urandom_range(0, 4) != 0);
      bus.rollback_signal = ($urandom_range(0, 11) == 0);
      set_op(6'($urandom_range(0, 33)), 4'($urandom),
             $urandom & 32'hFFFF_FFFC, a,
             ($urandom_range(0, 3) == 0) ? a : $urandom,
             ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 63));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
